// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: FSM states,
// opcode/funct values, instruction classes and datapath select codes.
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
    CLS_J, CLS_JR, CLS_JAL, CLS_HALT, CLS_ILL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MEM = 2'b01,
    WD_PC4 = 2'b10
  } wr_src_t;

endpackage

// File: rtl/mcpu_decode.sv
// Pure combinational op/funct decoder: instruction class, immediate-extension
// mode, ALU operation and an illegal-encoding flag.
module mcpu_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    cls     = CLS_ILL;
    ext_sel = 1'b0;
    alu_op  = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  begin cls = CLS_R;  alu_op = ALU_ADD; end
          FN_SUB:  begin cls = CLS_R;  alu_op = ALU_SUB; end
          FN_AND:  begin cls = CLS_R;  alu_op = ALU_AND; end
          FN_OR:   begin cls = CLS_R;  alu_op = ALU_OR;  end
          FN_SLT:  begin cls = CLS_R;  alu_op = ALU_SLT; end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDIU: begin cls = CLS_I;   ext_sel = 1'b1; alu_op = ALU_ADD; end
      OP_SLTI:  begin cls = CLS_I;   ext_sel = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI:  begin cls = CLS_I;   alu_op = ALU_AND; end
      OP_ORI:   begin cls = CLS_I;   alu_op = ALU_OR;  end
      OP_LW:    begin cls = CLS_LW;  ext_sel = 1'b1; end
      OP_SW:    begin cls = CLS_SW;  ext_sel = 1'b1; end
      OP_BEQ:   begin cls = CLS_BEQ; ext_sel = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:   begin cls = CLS_BNE; ext_sel = 1'b1; alu_op = ALU_SUB; end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through IF/ID/EXE/MEM/WB and
// drives the datapath control lines from the current state and decoded IR.
module multi_cycle_ctrl
  import mcpu_pkg::*;
#(
  parameter bit         MEM_WAIT_EN = 1'b1,
  parameter logic [4:0] RA_REG      = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic [1:0] WrDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [4:0] ra_sel,
  output logic [2:0] state_o,
  output logic       retired,
  output logic       illegal,
  output logic       halted
);

  state_t     state;
  cls_t       cls;
  logic       dec_ext;
  logic [2:0] dec_alu;
  logic       dec_ill;
  logic       mem_done;
  logic       br_taken;
  logic       last_cycle;

  mcpu_decode u_decode (
    .op      (op),
    .funct   (funct),
    .cls     (cls),
    .ext_sel (dec_ext),
    .alu_op  (dec_alu),
    .illegal (dec_ill)
  );

  assign mem_done = mem_ready || !MEM_WAIT_EN;
  assign br_taken = (cls == CLS_BEQ && zero) || (cls == CLS_BNE && !zero);
  assign ra_sel   = RA_REG;
  assign state_o  = state;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IF;
    end else begin
      unique case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          unique case (cls)
            CLS_J, CLS_JR, CLS_ILL: state <= S_IF;
            CLS_JAL:                state <= S_WB;
            CLS_HALT:               state <= S_HALT;
            default:                state <= S_EXE;
          endcase
        end
        S_EXE: begin
          unique case (cls)
            CLS_LW, CLS_SW:   state <= S_MEM;
            CLS_BEQ, CLS_BNE: state <= S_IF;
            default:          state <= S_WB;
          endcase
        end
        S_MEM:   if (mem_done) state <= (cls == CLS_LW) ? S_WB : S_IF;
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Outputs are forced idle while rst_n is low so no strobe (not even IRWre
  // in IF) can leak a write during reset.
  always_comb begin
    PCWre      = 1'b0;
    IRWre      = 1'b0;
    ExtSel     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    ALUOp      = ALU_ADD;
    PCSrc      = PC_SEQ;
    RegWre     = 1'b0;
    RegDst     = DST_RT;
    WrDataSrc  = WD_ALU;
    mRD        = 1'b0;
    mWR        = 1'b0;
    retired    = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    last_cycle = 1'b0;
    if (rst_n) begin
      if (state inside {S_ID, S_EXE, S_MEM, S_WB}) begin
        ExtSel  = dec_ext;
        ALUOp   = dec_alu;
        ALUSrcB = cls inside {CLS_I, CLS_LW, CLS_SW};
      end
      unique case (state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          illegal    = dec_ill;
          last_cycle = cls inside {CLS_J, CLS_JR, CLS_ILL};
        end
        S_EXE: last_cycle = cls inside {CLS_BEQ, CLS_BNE};
        S_MEM: begin
          mRD        = (cls == CLS_LW);
          mWR        = (cls == CLS_SW);
          last_cycle = (cls == CLS_SW) && mem_done;
        end
        S_WB: begin
          RegWre     = 1'b1;
          RegDst     = (cls == CLS_R) ? DST_RD : (cls == CLS_JAL) ? DST_RA : DST_RT;
          WrDataSrc  = (cls == CLS_LW) ? WD_MEM : (cls == CLS_JAL) ? WD_PC4 : WD_ALU;
          last_cycle = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
      if (last_cycle) begin
        PCWre   = 1'b1;
        retired = 1'b1;
        if (cls inside {CLS_J, CLS_JAL}) PCSrc = PC_JUMP;
        else if (cls == CLS_JR)          PCSrc = PC_RS;
        else if (br_taken)               PCSrc = PC_BRANCH;
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed scenarios plus random
// instruction streams compared cycle by cycle against a path-based model.
module tb_multi_cycle_ctrl;

  localparam logic [2:0] T_IF = 3'd0, T_ID = 3'd1, T_EXE = 3'd2,
                         T_MEM = 3'd3, T_WB = 3'd4, T_HALT = 3'd7;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_HALT, K_ILL} kind_t;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       extsel;
    logic       srca;
    logic       srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       regwre;
    logic [1:0] regdst;
    logic [1:0] wrsrc;
    logic       mrd;
    logic       mwr;
    logic       retired;
    logic       illegal;
    logic       halted;
    logic [2:0] state;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, RegWre, mRD, mWR;
  logic [2:0] ALUOp, state_o;
  logic [1:0] PCSrc, RegDst, WrDataSrc;
  logic [4:0] ra_sel;
  logic       retired, illegal, halted;
  vec_t       obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .RegWre(RegWre), .RegDst(RegDst), .WrDataSrc(WrDataSrc), .mRD(mRD),
    .mWR(mWR), .ra_sel(ra_sel), .state_o(state_o), .retired(retired),
    .illegal(illegal), .halted(halted)
  );

  assign obs = '{PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, PCSrc, RegWre,
                 RegDst, WrDataSrc, mRD, mWR, retired, illegal, halted, state_o};

  // ---------------- reference model ----------------
  function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: case (f)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return K_R;
               6'h08:                             return K_JR;
               default:                           return K_ILL;
             endcase
      6'h09, 6'h0C, 6'h0D, 6'h0A: return K_I;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h3F: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: case (f)
               6'h22: return 3'd1;
               6'h24: return 3'd2;
               6'h25: return 3'd3;
               6'h2A: return 3'd4;
               default: return 3'd0;
             endcase
      6'h0C: return 3'd2;
      6'h0D: return 3'd3;
      6'h0A: return 3'd4;
      6'h04, 6'h05: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Walks one instruction from IF to its last state, comparing every cycle.
  // Entry: in an IF cycle, >=2 time units before the next rising edge.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int waits);
    kind_t      k;
    logic [2:0] path[$];
    vec_t       exp;
    logic       last, taken, ext, srcb;
    int         m;
    k     = kind_of(o, f);
    ext   = (o inside {6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05});
    srcb  = (k inside {K_I, K_LW, K_SW});
    taken = (o == 6'h04) ? z : !z;
    path  = '{T_IF, T_ID};
    case (k)
      K_R, K_I: begin path.push_back(T_EXE); path.push_back(T_WB); end
      K_LW, K_SW: begin
        path.push_back(T_EXE);
        for (int i = 0; i <= waits; i++) path.push_back(T_MEM);
        if (k == K_LW) path.push_back(T_WB);
      end
      K_BR:    path.push_back(T_EXE);
      K_JAL:   path.push_back(T_WB);
      default: ;
    endcase
    m = 0;
    for (int i = 0; i < path.size(); i++) begin
      op        = o;
      funct     = f;
      zero      = (path[i] == T_EXE) ? z : 1'($urandom_range(0, 1));
      mem_ready = (path[i] == T_MEM) ? (m == waits) : 1'($urandom_range(0, 1));
      #1;
      last = (k != K_HALT) && (i == path.size() - 1);
      exp = '0;
      exp.state = path[i];
      if (path[i] == T_IF) begin
        exp.irwre = 1'b1;
      end else begin
        exp.extsel = ext;
        exp.srcb   = srcb;
        exp.aluop  = alu_of(o, f);
        if (path[i] == T_ID && k == K_ILL) exp.illegal = 1'b1;
        if (path[i] == T_MEM) begin
          exp.mrd = (k == K_LW);
          exp.mwr = (k == K_SW);
        end
        if (path[i] == T_WB) begin
          exp.regwre = 1'b1;
          exp.regdst = (k == K_R) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
          exp.wrsrc  = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
        end
        if (last) begin
          exp.pcwre   = 1'b1;
          exp.retired = 1'b1;
          if (k == K_J || k == K_JAL) exp.pcsrc = 2'b10;
          else if (k == K_JR)         exp.pcsrc = 2'b11;
          else if (k == K_BR && taken) exp.pcsrc = 2'b01;
        end
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h (state got %0d expected %0d)",
                 name, i, obs, exp, state_o, path[i]);
      end
      if (path[i] == T_MEM) m++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; op = 6'h23; funct = 6'h20; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_instr("add", 6'h00, 6'h20, 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 3);
    run_instr("lw_nowait", 6'h23, 6'h15, 1'b1, 0);
  endtask

  task automatic test_branches();
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0);
  endtask

  task automatic test_ori_jal();
    run_instr("ori", 6'h0D, 6'h3A, 1'b0, 0);
    checks++;
    if (ra_sel !== 5'd31) begin
      errors++;
      $display("FAIL ra_sel: got %0d expected 31", ra_sel);
    end
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0);
  endtask

  task automatic test_jumps_sw_illegal();
    run_instr("j", 6'h02, 6'h11, 1'b0, 0);
    run_instr("jr", 6'h00, 6'h08, 1'b1, 0);
    run_instr("sw_wait1", 6'h2B, 6'h00, 1'b0, 1);
    run_instr("illegal_op", 6'h3E, 6'h00, 1'b0, 0);
    run_instr("illegal_funct", 6'h00, 6'h3F, 1'b0, 0);
    run_instr("add_after_illegal", 6'h00, 6'h22, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [11:0] tbl[16] = '{
      {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
      {6'h00, 6'h2A}, {6'h09, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
      {6'h0A, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00},
      {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h00, 6'h08}, {6'h03, 6'h00}};
    logic [11:0] e;
    for (int n = 0; n < 40; n++) begin
      e = tbl[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) e = {6'h31, 6'h00};
      run_instr("random", e[11:6], e[5:0], 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_sw();
    int n;
    op = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    n = 0;
    while (state_o !== T_MEM && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (state_o !== T_MEM || mWR !== 1'b1) begin
      errors++;
      $display("FAIL sw_reach_mem: state %0d mWR %b expected state 3 mWR 1", state_o, mWR);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_in_mem: got %h expected 0", obs);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      checks++;
      if (retired !== 1'b0 || obs !== '0) begin
        errors++;
        $display("FAIL reset_hold: retired %b outputs %h expected 0", retired, obs);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("add_after_reset", 6'h00, 6'h24, 1'b0, 0);
  endtask

  task automatic test_halt();
    vec_t exp;
    run_instr("halt_entry", 6'h3F, 6'h00, 1'b0, 0);
    exp = '0;
    exp.halted = 1'b1;
    exp.state  = T_HALT;
    for (int i = 0; i < 20; i++) begin
      op = 6'($urandom); mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== T_IF || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state %0d halted %b expected 0 0", state_o, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("ori_after_halt", 6'h0D, 6'h00, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_ori_jal();
    test_jumps_sw_illegal();
    test_random();
    test_reset_mid_sw();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
